aes_key_sched: RTL and testbench

- Iterative AES-128 key schedule. Produces one 128-bit round key per request for the AddRoundKey stage that consumes the round transform's s_o output.
- The round controller loads the cipher key with start_i, then pulses next_i once per round.
- SubWord uses one shared S-box instance, one byte per cycle, to save area. Each step therefore costs a fixed multi-cycle latency, which overlaps with the round transform's own latency.

---
 rtl/aes_key_sched.sv | 203 ++++++++++++++++++++
 tb/tb_aes_key_sched.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched.sv
// aes_key_sched: iterative AES-128 key schedule, one round key per request.
//
// SubWord goes through one shared S-box, one byte per cycle. A step therefore
// takes four SUB cycles plus one UPD cycle.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous reset, active-low
//   start_i  in   load key_i, restart at round 0 (wins over everything)
//   key_i    in   cipher key, byte 0 = bits [127:120]
//   next_i   in   request the next round key (honoured only in READY)
//   prev_i   in   request the previous round key (AES_KEY_SCHED_INV_EN only)
//   rk_o     out  current round key, stable while valid_o=1
//   rnd_o    out  round index of rk_o
//   valid_o  out  rk_o/rnd_o valid, ready for next_i
//   busy_o   out  step in progress
//   done_o   out  one-cycle pulse when the end of the schedule is reached
//
// Build option: define AES_KEY_SCHED_INV_EN to add prev_i and backward stepping.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no key loaded, outputs invalid
// READY | rk_o/rnd_o valid, waiting for next_i / prev_i / start_i
// SUB   | RotWord+SubWord, one byte per cycle (cnt 0..3)
// UPD   | combine words, update rcon and round index
module aes_key_sched #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic         next_i,
`ifdef AES_KEY_SCHED_INV_EN
  input  logic         prev_i,
`endif
  output logic [127:0] rk_o,
  output logic [3:0]   rnd_o,
  output logic         valid_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [1:0] {IDLE, READY, SUB, UPD} state_t;

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  state_t       state_q, state_d;
  logic [1:0]   cnt_q;
  logic [7:0]   rcon_q;
  logic [31:0]  temp_q;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sub_src;
  logic [7:0]   sbox_in;
  logic [127:0] rk_step;
  logic [3:0]   rnd_step;
  logic [7:0]   rcon_step;
  logic         done_hit;

  assign {w0, w1, w2, w3} = rk_o;

`ifdef AES_KEY_SCHED_INV_EN
  logic       bwd_q, bwd_d;
  logic [7:0] rcon_prev;
  // Backward step undoes w1..w3 first; its SubWord input is the recovered w3.
  assign sub_src   = bwd_q ? (w3 ^ w2) : w3;
  assign rcon_prev = {1'b0, rcon_q[7:1]} ^ (rcon_q[0] ? 8'h8d : 8'h00);
`else
  assign sub_src = w3;
`endif

  // Byte (cnt+1) mod 4 of the source word lands in temp byte cnt (RotWord).
  always_comb begin
    sbox_in = 8'h00;
    case (cnt_q)
      2'd0: sbox_in = sub_src[23:16];
      2'd1: sbox_in = sub_src[15:8];
      2'd2: sbox_in = sub_src[7:0];
      2'd3: sbox_in = sub_src[31:24];
      default: sbox_in = 8'h00;
    endcase
  end

  always_comb begin
    logic [31:0] t, n0, n1, n2;
    t         = temp_q ^ {rcon_q, 24'h0};
    n0        = w0 ^ t;
    n1        = w1 ^ n0;
    n2        = w2 ^ n1;
    rk_step   = {n0, n1, n2, w3 ^ n2};
    rnd_step  = rnd_o + 4'd1;
    rcon_step = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    done_hit  = (rnd_step == LAST_RND);
`ifdef AES_KEY_SCHED_INV_EN
    if (bwd_q) begin
      rk_step   = {w0 ^ temp_q ^ {rcon_prev, 24'h0}, w1 ^ w0, w2 ^ w1, w3 ^ w2};
      rnd_step  = rnd_o - 4'd1;
      rcon_step = rcon_prev;
      done_hit  = (rnd_step == 4'd0);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
`ifdef AES_KEY_SCHED_INV_EN
    bwd_d = 1'b0;
`endif
    if (start_i) begin
      state_d = READY;
    end else begin
      case (state_q)
        READY: begin
          if (next_i && rnd_o < LAST_RND) state_d = SUB;
`ifdef AES_KEY_SCHED_INV_EN
          else if (prev_i && rnd_o != 4'd0) begin
            state_d = SUB;
            bwd_d   = 1'b1;
          end
`endif
        end
        SUB:     if (cnt_q == 2'd3) state_d = UPD;
        UPD:     state_d = READY;
        default: state_d = state_q;
      endcase
    end
    valid_o = (state_q == READY);
    busy_o  = (state_q == SUB) || (state_q == UPD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_o   <= '0;
      rnd_o  <= '0;
      done_o <= 1'b0;
      rcon_q <= 8'h01;
      cnt_q  <= '0;
      temp_q <= '0;
`ifdef AES_KEY_SCHED_INV_EN
      bwd_q  <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      if (start_i) begin
        rk_o   <= key_i;
        rnd_o  <= '0;
        rcon_q <= 8'h01;
        cnt_q  <= '0;
      end else begin
        case (state_q)
          READY: if (state_d == SUB) begin
            cnt_q <= '0;
`ifdef AES_KEY_SCHED_INV_EN
            bwd_q <= bwd_d;
`endif
          end
          SUB: begin
            case (cnt_q)
              2'd0:    temp_q[31:24] <= SBOX[sbox_in];
              2'd1:    temp_q[23:16] <= SBOX[sbox_in];
              2'd2:    temp_q[15:8]  <= SBOX[sbox_in];
              default: temp_q[7:0]   <= SBOX[sbox_in];
            endcase
            cnt_q <= cnt_q + 2'd1;
          end
          UPD: begin
            rk_o   <= rk_step;
            rnd_o  <= rnd_step;
            rcon_q <= rcon_step;
            done_o <= done_hit;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_key_sched.sv
// Bench for aes_key_sched: FIPS-197 key expansion vectors, scoreboard of
// expected round keys pushed when a step is requested, popped at valid_o.
module tb_aes_key_sched;

  logic         clk, rst_n, start_i, next_i;
  logic [127:0] key_i;
`ifdef AES_KEY_SCHED_INV_EN
  logic         prev_i;
`endif
  logic [127:0] rk_o;
  logic [3:0]   rnd_o;
  logic         valid_o, busy_o, done_o;

  aes_key_sched dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .key_i(key_i), .next_i(next_i),
`ifdef AES_KEY_SCHED_INV_EN
    .prev_i(prev_i),
`endif
    .rk_o(rk_o), .rnd_o(rnd_o), .valid_o(valid_o), .busy_o(busy_o), .done_o(done_o)
  );

  typedef struct packed {
    logic [127:0] rk;
    logic [3:0]   rnd;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] ks [0:10];
  int           tests_run = 0;
  int           tests_failed = 0;
  int           done_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done_o === 1'b1) done_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_key(input logic [127:0] k);
    key_i = k; start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  task automatic issue_next(input logic [127:0] k, input logic [3:0] r);
    exp_t e;
    e.rk = k; e.rnd = r;
    sb.push_back(e);
    next_i = 1'b1; tick(); next_i = 1'b0;
  endtask

  // Waits for valid_o; lat counts the cycles seen with valid_o low,
  // gap counts those cycles where busy_o was also low.
  task automatic wait_valid(output int lat, output int gap);
    lat = 0; gap = 0;
    while (valid_o !== 1'b1 && lat < 20) begin
      if (busy_o !== 1'b1) gap++;
      lat++;
      tick();
    end
  endtask

  task automatic test_reset();
    #3;
    tests_run++;
    if ({valid_o, busy_o, done_o, rnd_o, rk_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%b b=%b d=%b rnd=%0d rk=%h, expected all 0",
               valid_o, busy_o, done_o, rnd_o, rk_o);
    end
    tick(); rst_n = 1'b1; tick(); tick();
    tests_run++;
    if ({valid_o, busy_o, done_o, rnd_o, rk_o} !== '0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got v=%b rnd=%0d rk=%h, expected all 0", valid_o, rnd_o, rk_o);
    end
  endtask

  task automatic test_load();
    start_key(ks[0]);
    tests_run++;
    if ({valid_o, busy_o, rnd_o, rk_o} !== {1'b1, 1'b0, 4'd0, ks[0]}) begin
      tests_failed++;
      $display("FAIL key_load: got v=%b b=%b rnd=%0d rk=%h, expected v=1 b=0 rnd=0 rk=%h",
               valid_o, busy_o, rnd_o, rk_o, ks[0]);
    end
  endtask

  task automatic test_step1();
    int lat, gap;
    exp_t e;
    issue_next(ks[1], 4'd1);
    wait_valid(lat, gap);
    tests_run++;
    if (lat != 5) begin
      tests_failed++;
      $display("FAIL step1_latency: got %0d cycles, expected 5", lat);
    end
    tests_run++;
    if (gap != 0) begin
      tests_failed++;
      $display("FAIL step1_busy: %0d cycles with neither valid nor busy, expected 0", gap);
    end
    e = sb.pop_front();
    tests_run++;
    if ({rk_o, rnd_o, done_o} !== {e.rk, e.rnd, 1'b0}) begin
      tests_failed++;
      $display("FAIL step1_key: got rk=%h rnd=%0d done=%b, expected rk=%h rnd=%0d done=0",
               rk_o, rnd_o, done_o, e.rk, e.rnd);
    end
  endtask

  task automatic test_full();
    int lat, gap, d0;
    exp_t e;
    d0 = done_cnt;
    for (int r = 2; r <= 10; r++) begin
      issue_next(ks[r], 4'(r));
      wait_valid(lat, gap);
      e = sb.pop_front();
      tests_run++;
      if (lat != 5 || rk_o !== e.rk || rnd_o !== e.rnd) begin
        tests_failed++;
        $display("FAIL full_round%0d: got lat=%0d rk=%h rnd=%0d, expected lat=5 rk=%h rnd=%0d",
                 r, lat, rk_o, rnd_o, e.rk, e.rnd);
      end
    end
    tests_run++;
    if (done_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_at_last: got %b, expected 1", done_o);
    end
    tick();
    tests_run++;
    if (done_o !== 1'b0 || done_cnt - d0 != 1) begin
      tests_failed++;
      $display("FAIL done_pulse: got done=%b pulses=%0d, expected done=0 pulses=1",
               done_o, done_cnt - d0);
    end
    next_i = 1'b1; tick(); next_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if ({valid_o, busy_o, done_o, rnd_o, rk_o} !== {3'b100, 4'd10, ks[10]}) begin
        tests_failed++;
        $display("FAIL next_at_last: cycle %0d got v=%b b=%b d=%b rnd=%0d rk=%h, expected unchanged",
                 i, valid_o, busy_o, done_o, rnd_o, rk_o);
      end
      tick();
    end
  endtask

  task automatic test_abort();
    int lat, gap, d0;
    exp_t e;
    start_key(ks[0]);
    issue_next(ks[1], 4'd1);
    wait_valid(lat, gap);
    e = sb.pop_front();
    d0 = done_cnt;
    next_i = 1'b1; tick(); next_i = 1'b0;   // step 2 accepted, SUB cnt=0
    tick(); tick();                          // now in third SUB cycle
    key_i = ks[0]; start_i = 1'b1; tick(); start_i = 1'b0;
    tests_run++;
    if ({valid_o, busy_o, done_o, rnd_o, rk_o} !== {3'b100, 4'd0, ks[0]}) begin
      tests_failed++;
      $display("FAIL abort_reload: got v=%b b=%b d=%b rnd=%0d rk=%h, expected v=1 rnd=0 rk=%h",
               valid_o, busy_o, done_o, rnd_o, rk_o, ks[0]);
    end
    for (int i = 0; i < 5; i++) tick();
    tests_run++;
    if (done_cnt != d0 || rnd_o !== 4'd0) begin
      tests_failed++;
      $display("FAIL abort_no_done: got pulses=%0d rnd=%0d, expected pulses=0 rnd=0",
               done_cnt - d0, rnd_o);
    end
    issue_next(ks[1], 4'd1);
    wait_valid(lat, gap);
    e = sb.pop_front();
    tests_run++;
    if (lat != 5 || rk_o !== e.rk || rnd_o !== e.rnd) begin
      tests_failed++;
      $display("FAIL abort_restep: got lat=%0d rk=%h rnd=%0d, expected lat=5 rk=%h rnd=%0d",
               lat, rk_o, rnd_o, e.rk, e.rnd);
    end
  endtask

  task automatic test_start_next();
    int bad;
    key_i = ks[0]; start_i = 1'b1; next_i = 1'b1; tick(); start_i = 1'b0; next_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (valid_o !== 1'b1 || busy_o !== 1'b0 || rnd_o !== 4'd0 || rk_o !== ks[0]) bad++;
      tick();
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL start_beats_next: %0d cycles not at loaded key, expected 0 (rnd=%0d)", bad, rnd_o);
    end
  endtask

  task automatic test_back_to_back();
    int lat, gap, bad;
    exp_t e;
    issue_next(ks[1], 4'd1);
    next_i = 1'b1; tick(); next_i = 1'b0;    // ignored while busy
    wait_valid(lat, gap);
    e = sb.pop_front();
    tests_run++;
    if (lat != 4 || rk_o !== e.rk || rnd_o !== e.rnd) begin
      tests_failed++;
      $display("FAIL busy_next_step: got lat=%0d rk=%h rnd=%0d, expected lat=4 rk=%h rnd=%0d",
               lat, rk_o, rnd_o, e.rk, e.rnd);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (valid_o !== 1'b1 || rnd_o !== 4'd1) bad++;
      tick();
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL busy_next_dropped: %0d cycles off round 1, expected 0", bad);
    end
    issue_next(ks[2], 4'd2);
    wait_valid(lat, gap);
    e = sb.pop_front();
    issue_next(ks[3], 4'd3);
    wait_valid(lat, gap);
    e = sb.pop_front();
    tests_run++;
    if (lat != 5 || rk_o !== e.rk || rnd_o !== e.rnd) begin
      tests_failed++;
      $display("FAIL back_to_back: got lat=%0d rk=%h rnd=%0d, expected lat=5 rk=%h rnd=%0d",
               lat, rk_o, rnd_o, e.rk, e.rnd);
    end
  endtask

  task automatic test_zero_key();
    int lat, gap;
    exp_t e;
    logic [127:0] z [0:1];
    z[0] = 128'h62636363626363636263636362636363;
    z[1] = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    start_key('0);
    for (int r = 1; r <= 2; r++) begin
      issue_next(z[r-1], 4'(r));
      wait_valid(lat, gap);
      e = sb.pop_front();
      tests_run++;
      if (rk_o !== e.rk || rnd_o !== e.rnd) begin
        tests_failed++;
        $display("FAIL zero_key_round%0d: got rk=%h rnd=%0d, expected rk=%h rnd=%0d",
                 r, rk_o, rnd_o, e.rk, e.rnd);
      end
    end
  endtask

  task automatic test_async_reset();
    int bad;
    next_i = 1'b1; tick(); next_i = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({valid_o, busy_o, done_o, rnd_o, rk_o} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: got v=%b b=%b d=%b rnd=%0d rk=%h, expected all 0",
               valid_o, busy_o, done_o, rnd_o, rk_o);
    end
    tick(); tick(); rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if ({valid_o, busy_o, done_o, rnd_o, rk_o} !== '0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL reset_hold: %0d cycles with nonzero outputs before start, expected 0", bad);
    end
    start_key(ks[0]);
    tests_run++;
    if ({valid_o, rnd_o, rk_o} !== {1'b1, 4'd0, ks[0]}) begin
      tests_failed++;
      $display("FAIL reload_after_reset: got v=%b rnd=%0d rk=%h, expected v=1 rnd=0 rk=%h",
               valid_o, rnd_o, rk_o, ks[0]);
    end
  endtask

`ifdef AES_KEY_SCHED_INV_EN
  task automatic issue_prev(input logic [127:0] k, input logic [3:0] r);
    exp_t e;
    e.rk = k; e.rnd = r;
    sb.push_back(e);
    prev_i = 1'b1; tick(); prev_i = 1'b0;
  endtask

  task automatic test_inverse();
    int lat, gap, d0, bad;
    exp_t e;
    start_key(ks[0]);
    prev_i = 1'b1; tick(); prev_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (valid_o !== 1'b1 || rnd_o !== 4'd0) bad++;
      tick();
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL prev_at_zero: %0d cycles off round 0, expected 0", bad);
    end
    for (int r = 1; r <= 10; r++) begin
      issue_next(ks[r], 4'(r));
      wait_valid(lat, gap);
      e = sb.pop_front();
    end
    d0 = done_cnt;
    for (int r = 9; r >= 0; r--) begin
      issue_prev(ks[r], 4'(r));
      wait_valid(lat, gap);
      e = sb.pop_front();
      tests_run++;
      if (lat != 5 || rk_o !== e.rk || rnd_o !== e.rnd) begin
        tests_failed++;
        $display("FAIL inverse_round%0d: got lat=%0d rk=%h rnd=%0d, expected lat=5 rk=%h rnd=%0d",
                 r, lat, rk_o, rnd_o, e.rk, e.rnd);
      end
    end
    tick();
    tests_run++;
    if (done_cnt - d0 != 1) begin
      tests_failed++;
      $display("FAIL inverse_done: got %0d pulses, expected 1", done_cnt - d0);
    end
    e.rk = ks[1]; e.rnd = 4'd1;
    sb.push_back(e);
    next_i = 1'b1; prev_i = 1'b1; tick(); next_i = 1'b0; prev_i = 1'b0;
    wait_valid(lat, gap);
    e = sb.pop_front();
    tests_run++;
    if (rk_o !== e.rk || rnd_o !== e.rnd) begin
      tests_failed++;
      $display("FAIL next_beats_prev: got rk=%h rnd=%0d, expected rk=%h rnd=%0d",
               rk_o, rnd_o, e.rk, e.rnd);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; start_i = 1'b0; next_i = 1'b0; key_i = '0;
`ifdef AES_KEY_SCHED_INV_EN
    prev_i = 1'b0;
`endif
    ks[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ks[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    ks[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    ks[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    ks[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    ks[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    ks[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    ks[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    ks[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    ks[9]  = 128'hac7766f319fadc2128d12941575c006e;
    ks[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    test_reset();
    test_load();
    test_step1();
    test_full();
    test_abort();
    test_start_next();
    test_back_to_back();
    test_zero_key();
    test_async_reset();
`ifdef AES_KEY_SCHED_INV_EN
    test_inverse();
`endif
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
